// File: rtl/mux_scan_sequencer.sv
// Walks a 4:1 mux select through channels 0..3, dwelling DWELL cycles per channel,
// and assembles the sampled mux output into a 4-bit word with valid/changed strobes.
module mux_scan_sequencer #(
    parameter int DWELL = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       continuous,
    input  logic       abort,
    input  logic       mux_out,
    output logic [1:0] sel,
    output logic [3:0] sample,
    output logic       valid,
    output logic       changed,
    output logic       busy
);

    // Counter holds 0..DWELL-1; a 1-bit counter stays at 0 when DWELL=1.
    localparam int            CW   = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t        state_q, state_d;
    logic [1:0]    sel_q, sel_d;
    logic [CW-1:0] dwell_q, dwell_d;
    logic [3:0]    shadow_q, shadow_d;
    logic [3:0]    sample_q, sample_d;
    logic          valid_q, valid_d;
    logic          changed_q, changed_d;
    logic          have_prior_q, have_prior_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sel_q        <= '0;
            dwell_q      <= '0;
            shadow_q     <= '0;
            sample_q     <= '0;
            valid_q      <= 1'b0;
            changed_q    <= 1'b0;
            have_prior_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            dwell_q      <= dwell_d;
            shadow_q     <= shadow_d;
            sample_q     <= sample_d;
            valid_q      <= valid_d;
            changed_q    <= changed_d;
            have_prior_q <= have_prior_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        dwell_d      = dwell_q;
        shadow_d     = shadow_q;
        sample_d     = sample_q;
        valid_d      = 1'b0;
        changed_d    = 1'b0;
        have_prior_d = have_prior_q;
        case (state_q)
            IDLE: begin
                // abort in IDLE suppresses a coincident start
                if (start && !abort) begin
                    state_d = SCAN;
                    sel_d   = '0;
                    dwell_d = '0;
                end
            end
            SCAN: begin
                if (abort) begin
                    state_d = IDLE;
                    sel_d   = '0;
                    dwell_d = '0;
                end else if (dwell_q == LAST) begin
                    shadow_d[sel_q] = mux_out;
                    dwell_d         = '0;
                    if (sel_q != 2'd3) begin
                        sel_d = sel_q + 2'd1;
                    end else begin
                        sample_d     = {mux_out, shadow_q[2:0]};
                        valid_d      = 1'b1;
                        changed_d    = have_prior_q && (sample_d != sample_q);
                        have_prior_d = 1'b1;
                        sel_d        = '0;
                        if (!continuous) state_d = IDLE;
                    end
                end else begin
                    dwell_d = dwell_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sel     = sel_q;
        sample  = sample_q;
        valid   = valid_q;
        changed = changed_q;
        busy    = (state_q == SCAN);
    end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Three sequencers (DWELL=2,1,3) each driving its own modelled 4:1 mux; a scoreboard
// holds the expected completion cycle, word and change flag of every scan.
module tb_mux_scan_sequencer;

    typedef struct {
        int         cyc;
        logic [3:0] s;
        logic       c;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       st   [3];
    logic       cont [3];
    logic       ab   [3];
    logic [3:0] in_v [3];
    logic       mo   [3];
    logic [1:0] sel  [3];
    logic [3:0] smp  [3];
    logic       vld  [3];
    logic       chg  [3];
    logic       bsy  [3];

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   e;
    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    logic       hp [3];
    logic [3:0] ps [3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign mo[0] = in_v[0][sel[0]];
    assign mo[1] = in_v[1][sel[1]];
    assign mo[2] = in_v[2][sel[2]];

    mux_scan_sequencer #(.DWELL(2)) u_d2 (
        .clk(clk), .rst_n(rst_n), .start(st[0]), .continuous(cont[0]), .abort(ab[0]),
        .mux_out(mo[0]), .sel(sel[0]), .sample(smp[0]), .valid(vld[0]),
        .changed(chg[0]), .busy(bsy[0]));
    mux_scan_sequencer #(.DWELL(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .start(st[1]), .continuous(cont[1]), .abort(ab[1]),
        .mux_out(mo[1]), .sel(sel[1]), .sample(smp[1]), .valid(vld[1]),
        .changed(chg[1]), .busy(bsy[1]));
    mux_scan_sequencer #(.DWELL(3)) u_d3 (
        .clk(clk), .rst_n(rst_n), .start(st[2]), .continuous(cont[2]), .abort(ab[2]),
        .mux_out(mo[2]), .sel(sel[2]), .sample(smp[2]), .valid(vld[2]),
        .changed(chg[2]), .busy(bsy[2]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference model of the change flag: compares against the previous completed scan.
    task automatic push(input int i, input int ec, input logic [3:0] s);
        exp_t x;
        x.cyc = ec;
        x.s   = s;
        x.c   = hp[i] && (s != ps[i]);
        hp[i] = 1'b1;
        ps[i] = s;
        case (i)
            0: q0.push_back(x);
            1: q1.push_back(x);
            default: q2.push_back(x);
        endcase
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            hp[i] = 1'b0;
            ps[i] = 4'h0;
        end
    endtask

    task automatic mon(input int i);
        exp_t x;
        int   sz;
        sz = (i == 0) ? q0.size() : (i == 1) ? q1.size() : q2.size();
        if (sz == 0) begin
            chk($sformatf("unexp_valid%0d", i), 32'd1, 32'd0);
        end else begin
            case (i)
                0: x = q0.pop_front();
                1: x = q1.pop_front();
                default: x = q2.pop_front();
            endcase
            chk($sformatf("valid_cyc%0d", i), cyc, x.cyc);
            chk($sformatf("sample%0d", i), {28'd0, smp[i]}, {28'd0, x.s});
            chk($sformatf("changed%0d", i), {31'd0, chg[i]}, {31'd0, x.c});
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++)
            if (vld[i] === 1'b1) mon(i);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            st[i] = 0; cont[i] = 0; ab[i] = 0; in_v[i] = 4'h0;
        end
        model_reset();
        #3;
        for (int i = 0; i < 3; i++)
            chk($sformatf("rst_outs%0d", i),
                {23'd0, sel[i], smp[i], vld[i], chg[i], bsy[i]}, 32'd0);
        tick(2);
        rst_n = 1'b1;

        // single scan, DWELL=2
        in_v[0] = 4'b1010; st[0] = 1;
        tick(1); e = cyc; st[0] = 0;
        push(0, e + 8, 4'b1010);
        chk("sel_e0", {30'd0, sel[0]}, 32'd0);
        chk("busy_e0", {31'd0, bsy[0]}, 32'd1);
        for (int k = 1; k < 8; k++) begin
            tick(1);
            chk($sformatf("sel_e%0d", k), {30'd0, sel[0]}, k / 2);
            chk($sformatf("busy_e%0d", k), {31'd0, bsy[0]}, 32'd1);
        end
        tick(1);
        chk("valid_e8", {31'd0, vld[0]}, 32'd1);
        chk("busy_e8", {31'd0, bsy[0]}, 32'd0);
        chk("sel_e8", {30'd0, sel[0]}, 32'd0);

        // continuous change detect, DWELL=1
        in_v[1] = 4'b0110; cont[1] = 1; st[1] = 1;
        tick(1); e = cyc; st[1] = 0;
        push(1, e + 4, 4'b0110);
        tick(4);
        chk("cont_busy", {31'd0, bsy[1]}, 32'd1);
        in_v[1] = 4'b0111;
        push(1, e + 8, 4'b0111);
        push(1, e + 12, 4'b0111);
        tick(5);
        cont[1] = 0;
        tick(3);
        chk("cont_stop_busy1", {31'd0, bsy[1]}, 32'd0);
        tick(1);
        chk("cont_stop_busy1b", {31'd0, bsy[1]}, 32'd0);

        // abort during channel-2 dwell, DWELL=3
        in_v[2] = 4'b1101; st[2] = 1;
        tick(1); e = cyc; st[2] = 0;
        push(2, e + 12, 4'b1101);
        tick(12);
        chk("d3_busy_done", {31'd0, bsy[2]}, 32'd0);
        in_v[2] = 4'b0010; st[2] = 1;
        tick(1); st[2] = 0;
        tick(6);
        chk("d3_sel_pre_abort", {30'd0, sel[2]}, 32'd2);
        ab[2] = 1;
        tick(1); ab[2] = 0;
        chk("abort_busy", {31'd0, bsy[2]}, 32'd0);
        chk("abort_sel", {30'd0, sel[2]}, 32'd0);
        chk("abort_sample", {28'd0, smp[2]}, 32'hD);
        tick(15);
        ab[2] = 1; st[2] = 1;
        tick(1); ab[2] = 0; st[2] = 0;
        chk("abort_blocks_start", {31'd0, bsy[2]}, 32'd0);
        st[2] = 1;
        tick(1); e = cyc; st[2] = 0;
        push(2, e + 12, 4'b0010);
        tick(13);

        // start held high throughout a single scan
        in_v[0] = 4'b0101; st[0] = 1;
        tick(1); e = cyc;
        push(0, e + 8, 4'b0101);
        tick(7);
        chk("held_busy_e7", {31'd0, bsy[0]}, 32'd1);
        tick(1);
        chk("held_busy_e8", {31'd0, bsy[0]}, 32'd0);
        tick(1);
        chk("held_restart_e9", {31'd0, bsy[0]}, 32'd1);
        chk("held_restart_sel", {30'd0, sel[0]}, 32'd0);
        st[0] = 0; ab[0] = 1;
        tick(1); ab[0] = 0;
        chk("held_abort_busy", {31'd0, bsy[0]}, 32'd0);

        // async reset mid-scan
        in_v[0] = 4'b1111; st[0] = 1;
        tick(1); st[0] = 0;
        tick(5);
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst_outs", {23'd0, sel[0], smp[0], vld[0], chg[0], bsy[0]}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(12);

        // continuous dropped during second scan, DWELL=2
        in_v[0] = 4'b0011; cont[0] = 1; st[0] = 1;
        tick(1); e = cyc; st[0] = 0;
        push(0, e + 8, 4'b0011);
        push(0, e + 16, 4'b0011);
        tick(10);
        cont[0] = 0;
        tick(6);
        chk("stop_busy_e16", {31'd0, bsy[0]}, 32'd0);
        tick(1);
        chk("stop_busy_e17", {31'd0, bsy[0]}, 32'd0);
        tick(4);

        chk("sb_left0", q0.size(), 32'd0);
        chk("sb_left1", q1.size(), 32'd0);
        chk("sb_left2", q2.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
